// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and helpers for the two-requester RAM arbiter.
//   arb_state_e  - arbiter ownership state (idle / requester 0 owns / requester 1 owns)
//   REQ0, REQ1   - requester identifiers used by last_grant and rd_owner
//   cnt_width()  - width of a beat counter able to hold 0..burst_max
package ram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Bits needed to count 0..burst_max inclusive; never less than one bit.
  function automatic int cnt_width(input int burst_max);
    int w;
    w = $clog2(burst_max + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational grant decision for the two-requester RAM arbiter.
// Inputs : state (current owner), cnt (beats granted to the current owner),
//          valid0/valid1 (pending requests), last_grant (most recent winner).
// Outputs: gnt0/gnt1 (one-hot or zero grant), state_nxt (owner after this cycle).
// The owner keeps the grant until it drops valid, or until it has used
// BURST_MAX beats while the other requester waits. Ties from idle go to the
// requester that did not win last.
module rr_pick2
  import ram_arb_pkg::*;
#(
  parameter int BURST_MAX = 4,
  parameter int CNT_W     = cnt_width(BURST_MAX)
) (
  input  arb_state_e       state,
  input  logic [CNT_W-1:0] cnt,
  input  logic             valid0,
  input  logic             valid1,
  input  logic             last_grant,
  output logic             gnt0,
  output logic             gnt1,
  output arb_state_e       state_nxt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state)
      ST_OWN0: begin
        if (valid0 && ((cnt < CNT_MAX) || !valid1)) gnt0 = 1'b1;
        else if (valid1)                             gnt1 = 1'b1;
      end
      ST_OWN1: begin
        if (valid1 && ((cnt < CNT_MAX) || !valid0)) gnt1 = 1'b1;
        else if (valid0)                             gnt0 = 1'b1;
      end
      default: begin
        if (valid0 && valid1) begin
          if (last_grant == REQ1) gnt0 = 1'b1;
          else                    gnt1 = 1'b1;
        end else if (valid0) begin
          gnt0 = 1'b1;
        end else if (valid1) begin
          gnt1 = 1'b1;
        end
      end
    endcase

    if (gnt0)      state_nxt = ST_OWN0;
    else if (gnt1) state_nxt = ST_OWN1;
    else           state_nxt = ST_IDLE;
  end

endmodule

// File: rtl/sync_ram_arbiter.sv
// sync_ram_arbiter: round-robin, burst-bounded arbiter in front of a
// single-port synchronous RAM (one-cycle registered read, read-first).
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   reqN_valid/we/addr/wdata (in)    requester N access, held until accepted
//   reqN_ready (out)                 access N accepted this cycle
//   rspN_valid/rdata (out)           read data for requester N, one cycle
//                                    after acceptance
//   ram_we/ram_addr/ram_din (out)    RAM drive from the granted requester
//   ram_dout (in)                    RAM registered read data
//   dbg_state (out)                  current arbiter state, for observation
// Handshake: a transfer happens on a rising edge where reqN_valid and
// reqN_ready are both high; ready is combinational from state and both
// valids, and is held low while rst_n is low. Responses have no backpressure.
module sync_ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int BURST_MAX  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output arb_state_e            dbg_state
);

  localparam int               CNT_W   = cnt_width(BURST_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             rd_pend_q, rd_pend_d;
  logic             rd_owner_q, rd_owner_d;

  logic             pick_gnt0, pick_gnt1;
  arb_state_e       pick_state;
  logic             gnt0, gnt1;

  rr_pick2 #(
    .BURST_MAX (BURST_MAX),
    .CNT_W     (CNT_W)
  ) u_pick (
    .state      (state_q),
    .cnt        (cnt_q),
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant_q),
    .gnt0       (pick_gnt0),
    .gnt1       (pick_gnt1),
    .state_nxt  (pick_state)
  );

  // Gate with rst_n so nothing is accepted or written while reset is held,
  // including the cycle in which reset asserts.
  assign gnt0 = pick_gnt0 & rst_n;
  assign gnt1 = pick_gnt1 & rst_n;

  always_comb begin
    state_d = pick_state;

    // Continuing owner counts up and saturates; a fresh owner starts at 1.
    if (((state_q == ST_OWN0) && gnt0) || ((state_q == ST_OWN1) && gnt1)) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end else if (gnt0 || gnt1) begin
      cnt_d = CNT_W'(1);
    end else begin
      cnt_d = '0;
    end

    last_grant_d = last_grant_q;
    if (gnt1)      last_grant_d = REQ1;
    else if (gnt0) last_grant_d = REQ0;

    rd_pend_d  = (gnt0 && !req0_we) || (gnt1 && !req1_we);
    rd_owner_d = gnt1 ? REQ1 : REQ0;

    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (gnt0) begin
      ram_we   = req0_we;
      ram_addr = req0_addr;
      ram_din  = req0_wdata;
    end else if (gnt1) begin
      ram_we   = req1_we;
      ram_addr = req1_addr;
      ram_din  = req1_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_grant_q <= REQ1;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= REQ0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign rsp0_valid = rd_pend_q && (rd_owner_q == REQ0);
  assign rsp1_valid = rd_pend_q && (rd_owner_q == REQ1);
  assign rsp0_rdata = ram_dout;
  assign rsp1_rdata = ram_dout;

  assign dbg_state = state_q;

endmodule

// File: tb/tb_sync_ram_arbiter.sv
// Directed testbench for sync_ram_arbiter. Two instances share one stimulus
// stream: u_dut4 (BURST_MAX=4) and u_dut1 (BURST_MAX=1), each with its own
// read-first synchronous RAM model initialised to mem[i] = 8'h11 * i.
module tb_sync_ram_arbiter;
  import ram_arb_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;

  // Clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Shared requester inputs
  logic          req0_valid, req0_we, req1_valid, req1_we;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_wdata, req1_wdata;

  // BURST_MAX=4 instance
  logic          b4_ready0, b4_ready1, b4_rsp0_valid, b4_rsp1_valid, b4_ram_we;
  logic [DW-1:0] b4_rsp0_rdata, b4_rsp1_rdata, b4_ram_din, b4_ram_dout;
  logic [AW-1:0] b4_ram_addr;
  arb_state_e    b4_state;

  // BURST_MAX=1 instance
  logic          b1_ready0, b1_ready1, b1_rsp0_valid, b1_rsp1_valid, b1_ram_we;
  logic [DW-1:0] b1_rsp0_rdata, b1_rsp1_rdata, b1_ram_din, b1_ram_dout;
  logic [AW-1:0] b1_ram_addr;
  arb_state_e    b1_state;

  logic [DW-1:0] mem4 [16] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
                               8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
  logic [DW-1:0] mem1 [16] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
                               8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};

  always @(posedge clk) begin
    if (b4_ram_we) mem4[b4_ram_addr] <= b4_ram_din;
    b4_ram_dout <= mem4[b4_ram_addr];
    if (b1_ram_we) mem1[b1_ram_addr] <= b1_ram_din;
    b1_ram_dout <= mem1[b1_ram_addr];
  end

  sync_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_MAX(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(b4_ready0), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(b4_rsp0_valid), .rsp0_rdata(b4_rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(b4_ready1), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(b4_rsp1_valid), .rsp1_rdata(b4_rsp1_rdata),
    .ram_we(b4_ram_we), .ram_addr(b4_ram_addr), .ram_din(b4_ram_din),
    .ram_dout(b4_ram_dout), .dbg_state(b4_state)
  );

  sync_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_MAX(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(b1_ready0), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(b1_rsp0_valid), .rsp0_rdata(b1_rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(b1_ready1), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(b1_rsp1_valid), .rsp1_rdata(b1_rsp1_rdata),
    .ram_we(b1_ram_we), .ram_addr(b1_ram_addr), .ram_din(b1_ram_din),
    .ram_dout(b1_ram_dout), .dbg_state(b1_state)
  );

  // Scoreboard: {owner, expected read data}
  int         checks   = 0;
  int         failures = 0;
  logic [8:0] exp_q[$];
  logic [8:0] e;
  logic       owner;

  // Driver task
  task automatic set_req(input logic v0, input logic we0, input logic [AW-1:0] a0,
                         input logic [DW-1:0] d0, input logic v1, input logic we1,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rsp_b4(input string tag, input logic [8:0] x);
    check({tag, "_rsp0_valid"}, 32'(b4_rsp0_valid), 32'(!x[8]));
    check({tag, "_rsp1_valid"}, 32'(b4_rsp1_valid), 32'(x[8]));
    check({tag, "_rdata"}, 32'(x[8] ? b4_rsp1_rdata : b4_rsp0_rdata), 32'(x[7:0]));
  endtask

  task automatic rsp_b1(input string tag, input logic [8:0] x);
    check({tag, "_rsp0_valid"}, 32'(b1_rsp0_valid), 32'(!x[8]));
    check({tag, "_rsp1_valid"}, 32'(b1_rsp1_valid), 32'(x[8]));
    check({tag, "_rdata"}, 32'(x[8] ? b1_rsp1_rdata : b1_rsp0_rdata), 32'(x[7:0]));
  endtask

  initial begin
    // Reset held, both requesters present writes: nothing may be accepted.
    set_req(1'b1, 1'b1, 4'h7, 8'hEE, 1'b1, 1'b1, 4'h7, 8'hDD);
    repeat (2) @(negedge clk);
    check("rst_ready0", 32'(b4_ready0), 32'd0);
    check("rst_ready1", 32'(b4_ready1), 32'd0);
    check("rst_rsp0_valid", 32'(b4_rsp0_valid), 32'd0);
    check("rst_rsp1_valid", 32'(b4_rsp1_valid), 32'd0);
    check("rst_ram_we", 32'(b4_ram_we), 32'd0);
    check("rst_ram_addr", 32'(b4_ram_addr), 32'd0);
    check("rst_ram_din", 32'(b4_ram_din), 32'd0);
    check("rst_state", 32'(b4_state), 32'(ST_IDLE));

    // Tie on first cycle after reset: req0 wins, req1 follows once req0 drops.
    @(negedge clk);
    rst_n = 1'b1;
    set_req(1'b1, 1'b0, 4'h5, 8'h00, 1'b1, 1'b0, 4'h6, 8'h00);
    #1;
    check("tie_ready0", 32'(b4_ready0), 32'd1);
    check("tie_ready1", 32'(b4_ready1), 32'd0);
    check("tie_ram_addr", 32'(b4_ram_addr), 32'h5);
    @(negedge clk);
    rsp_b4("tie_r0", {REQ0, 8'h55});
    set_req(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'h6, 8'h00);
    #1;
    check("tie_ready0_b", 32'(b4_ready0), 32'd0);
    check("tie_ready1_b", 32'(b4_ready1), 32'd1);
    @(negedge clk);
    rsp_b4("tie_r1", {REQ1, 8'h66});
    set_req(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);

    // Contention, BURST_MAX=4: 0,0,0,0,1,1,1,1,0,0,0,0.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        rsp_b4("cont", e);
      end
      set_req(1'b1, 1'b0, 4'h8, 8'h00, 1'b1, 1'b0, 4'h9, 8'h00);
      #1;
      owner = ((i / 4) % 2) == 1;
      check("cont_ready0", 32'(b4_ready0), 32'(!owner));
      check("cont_ready1", 32'(b4_ready1), 32'(owner));
      exp_q.push_back({owner, owner ? 8'h99 : 8'h88});
    end
    @(negedge clk);
    e = exp_q.pop_front();
    rsp_b4("cont_last", e);
    set_req(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);

    // Single requester: write 1<-A5, 2<-3C, read 1, read 2.
    @(negedge clk);
    set_req(1'b1, 1'b1, 4'h1, 8'hA5, 1'b0, 1'b0, 4'h0, 8'h00);
    #1;
    check("wr1_ready0", 32'(b4_ready0), 32'd1);
    check("wr1_ready1", 32'(b4_ready1), 32'd0);
    check("wr1_ram_we", 32'(b4_ram_we), 32'd1);
    check("wr1_ram_addr", 32'(b4_ram_addr), 32'h1);
    check("wr1_ram_din", 32'(b4_ram_din), 32'hA5);
    @(negedge clk);
    check("wr1_no_rsp", 32'(b4_rsp0_valid), 32'd0);
    set_req(1'b1, 1'b1, 4'h2, 8'h3C, 1'b0, 1'b0, 4'h0, 8'h00);
    #1;
    check("wr2_ready0", 32'(b4_ready0), 32'd1);
    @(negedge clk);
    check("wr2_no_rsp", 32'(b4_rsp0_valid), 32'd0);
    set_req(1'b1, 1'b0, 4'h1, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
    #1;
    check("rd1_ready0", 32'(b4_ready0), 32'd1);
    check("rd1_ram_we", 32'(b4_ram_we), 32'd0);
    @(negedge clk);
    rsp_b4("rd1", {REQ0, 8'hA5});
    set_req(1'b1, 1'b0, 4'h2, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
    #1;
    check("rd2_ready0", 32'(b4_ready0), 32'd1);
    @(negedge clk);
    rsp_b4("rd2", {REQ0, 8'h3C});
    set_req(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);

    // Write-then-read hazard: req1 writes 3<-FF, req0 reads 3 next cycle.
    @(negedge clk);
    set_req(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 4'h3, 8'hFF);
    #1;
    check("haz_wr_ready1", 32'(b4_ready1), 32'd1);
    check("haz_wr_ram_we", 32'(b4_ram_we), 32'd1);
    @(negedge clk);
    set_req(1'b1, 1'b0, 4'h3, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
    #1;
    check("haz_rd_ready0", 32'(b4_ready0), 32'd1);
    @(negedge clk);
    rsp_b4("haz", {REQ0, 8'hFF});
    set_req(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);

    // Reset in the cycle after a read is accepted.
    @(negedge clk);
    set_req(1'b1, 1'b0, 4'h4, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
    #1;
    check("prr_ready0", 32'(b4_ready0), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    set_req(1'b1, 1'b1, 4'h7, 8'hD0, 1'b1, 1'b1, 4'h7, 8'hD1);
    #1;
    check("mrst_rsp0_valid", 32'(b4_rsp0_valid), 32'd0);
    check("mrst_rsp1_valid", 32'(b4_rsp1_valid), 32'd0);
    check("mrst_ready0", 32'(b4_ready0), 32'd0);
    check("mrst_ready1", 32'(b4_ready1), 32'd0);
    check("mrst_ram_we", 32'(b4_ram_we), 32'd0);
    check("mrst_ram_addr", 32'(b4_ram_addr), 32'd0);
    check("mrst_ram_din", 32'(b4_ram_din), 32'd0);
    check("mrst_state", 32'(b4_state), 32'(ST_IDLE));
    @(negedge clk);
    check("mrst_rsp0_valid_b", 32'(b4_rsp0_valid), 32'd0);
    check("mrst_b1_rsp0_valid", 32'(b1_rsp0_valid), 32'd0);
    check("mrst_no_write", 32'(mem4[7]), 32'h77);
    rst_n = 1'b1;
    set_req(1'b1, 1'b0, 4'h5, 8'h00, 1'b1, 1'b0, 4'h6, 8'h00);
    #1;
    check("mrst_tie_ready0", 32'(b4_ready0), 32'd1);
    check("mrst_tie_ready1", 32'(b4_ready1), 32'd0);
    check("mrst_tie_b1_ready0", 32'(b1_ready0), 32'd1);
    @(negedge clk);
    rsp_b4("mrst_tie", {REQ0, 8'h55});
    set_req(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);

    // BURST_MAX=1: last grant was req0, so contention starts with req1.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        rsp_b1("alt", e);
      end
      set_req(1'b1, 1'b0, 4'h8, 8'h00, 1'b1, 1'b0, 4'h9, 8'h00);
      #1;
      owner = (i % 2) == 0;
      check("alt_ready0", 32'(b1_ready0), 32'(!owner));
      check("alt_ready1", 32'(b1_ready1), 32'(owner));
      exp_q.push_back({owner, owner ? 8'h99 : 8'h88});
    end
    @(negedge clk);
    e = exp_q.pop_front();
    rsp_b1("alt_last", e);
    set_req(1'b0, 1'b1, 4'hF, 8'h5A, 1'b0, 1'b1, 4'hE, 8'hA5);
    #1;
    check("idle_ram_we", 32'(b1_ram_we), 32'd0);
    check("idle_ram_addr", 32'(b1_ram_addr), 32'd0);
    check("idle_ram_din", 32'(b1_ram_din), 32'd0);
    @(negedge clk);
    check("idle_state", 32'(b1_state), 32'(ST_IDLE));
    set_req(1'b1, 1'b0, 4'h8, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
    #1;
    check("solo_ready0", 32'(b1_ready0), 32'd1);
    @(negedge clk);
    rsp_b1("solo_a", {REQ0, 8'h88});
    #1;
    check("solo_keep_ready0", 32'(b1_ready0), 32'd1);
    @(negedge clk);
    rsp_b1("solo_b", {REQ0, 8'h88});
    set_req(1'b1, 1'b0, 4'h8, 8'h00, 1'b1, 1'b0, 4'h9, 8'h00);
    #1;
    check("sw_ready0", 32'(b1_ready0), 32'd0);
    check("sw_ready1", 32'(b1_ready1), 32'd1);
    @(negedge clk);
    rsp_b1("sw_a", {REQ1, 8'h99});
    #1;
    check("sw_back_ready0", 32'(b1_ready0), 32'd1);
    @(negedge clk);
    rsp_b1("sw_b", {REQ0, 8'h88});
    set_req(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
    @(negedge clk);
    check("end_state", 32'(b1_state), 32'(ST_IDLE));
    check("end_rsp0_valid", 32'(b1_rsp0_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_ram_arbiter.md
# sync_ram_arbiter

Two-requester arbiter and sequencer for the team's single-port synchronous RAM: one read-first port, one-cycle registered read, write on clock edge. It sits between two independent masters and the RAM instance, and grants at most one access per cycle. Arbitration is round-robin, with bounded bursts. It returns read data to the correct requester one cycle after acceptance.

## Interface
- DATA_WIDTH, 8, RAM word width
- ADDR_WIDTH, 4, RAM address width (2**ADDR_WIDTH words)
- BURST_MAX, 4, max consecutive grants to one requester while the other waits; legal range ≥1
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- reqN_valid  in  1  requester N (N=0,1) has an access pending
- reqN_ready  out  1  access N accepted this cycle
- reqN_we  in  1  1=write, 0=read
- reqN_addr  in  ADDR_WIDTH  access address
- reqN_wdata  in  DATA_WIDTH  write data
- rspN_valid  out  1  read data for requester N present this cycle
- rspN_rdata  out  DATA_WIDTH  read data; meaningful only with rspN_valid
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_din  out  DATA_WIDTH  RAM write data
- ram_dout  in  DATA_WIDTH  RAM registered read data

## Operation
- **Handshake:**
  - Transfer occurs when reqN_valid && reqN_ready at a rising edge.
  - A requester holds valid, we, addr and wdata stable until accepted.
  - reqN_ready is combinational from the current state and both valids; it never asserts while rst_n is low.
- **States:** IDLE, OWN0, OWN1. beat_cnt is sized for 0..BURST_MAX. last_grant is 1 bit, reset 1, so requester 0 wins the first tie.
- **From IDLE:**
  - Neither valid: stay IDLE.
  - One valid: grant it, go to OWNk, cnt=1.
  - Both valid: grant the requester ≠ last_grant.
- **From OWNk:**
  - Owner keeps the grant when valid_k && (cnt<BURST_MAX || !valid_other). cnt=min(cnt+1, BURST_MAX).
  - Grant switches when valid_other && (!valid_k || cnt==BURST_MAX). Go to OWNother, cnt=1.
  - Neither valid: go to IDLE, cnt=0.
- **RAM drive:**
  - The granted requester's we/addr/wdata drive the RAM combinationally.
  - With no grant: ram_we=0, ram_addr=0, ram_din=0.
- **Read tracking:** registered rd_pend and rd_owner.
  - An accepted read sets rd_pend=1 and rd_owner=N for one cycle.
  - rspN_valid = rd_pend && rd_owner==N.
  - Both rspN_rdata are driven from ram_dout.
- **Writes:** posted; no response.
- At most one access per cycle; at most one rsp_valid high per cycle.

## Timing
- Read latency: accepted at edge T, so rspN_valid is high and ram_dout is valid in the cycle after T. There is no backpressure on responses.
- Full throughput is one access per cycle, including alternating requesters and back-to-back reads.
- Write at edge T followed by a read of the same address at T+1 returns the new data.
- With both valid continuously, grants follow 0×BURST_MAX, 1×BURST_MAX, and so on. With BURST_MAX=1 they strictly alternate.
- **Reset values:** state=IDLE, cnt=0, last_grant=1, rd_pend=0, all rsp_valid=0, all ready=0, ram_we=0, ram_addr=0, ram_din=0.
- **Reset mid-operation:**
  - An in-flight read response is dropped.
  - A write presented in the same cycle reset asserts is not performed; ram_we is forced low.

## Structure
- Package ram_arb_pkg holds:
  - the state typedef (IDLE/OWN0/OWN1);
  - requester ID constants REQ0=0, REQ1=1;
  - the helper computing the beat-counter width from BURST_MAX.
- Sub-module rr_pick2 holds the combinational grant decision. Inputs: state, cnt, valids, last_grant. Outputs: gnt0, gnt1, next state.
- The top level holds the registers, RAM muxing and response tracking.
- The RAM is external; the bench instantiates the existing single-port sync RAM.

## Test plan
- **Single requester, sequential write/read:** req0 writes 0x1←A5, 0x2←3C, then reads 0x1, 0x2. Expected: ready0 high every cycle, rsp0_valid one cycle after each read with A5 then 3C, and rsp1_valid never high.
- **Contention, BURST_MAX=4:** both valid continuously for 12 reads. Expected grant order: 0,0,0,0,1,1,1,1,0,0,0,0. Each rsp goes only to the granted owner, with the correct data.
- **Tie on first cycle after reset:** both assert valid. Expected: req0 granted first; req1 granted once req0 drops valid.
- **Write-then-read hazard:** req1 writes 0x3←FF at T, req0 reads 0x3 at T+1. Expected: rsp0_rdata=FF at T+2.
- **Reset during pending read:** deassert rst_n in the cycle after a read is accepted. Expected: rsp_valid is 0 throughout reset, all outputs take their reset values, and after release req0 wins the first tie.
- **BURST_MAX=1, idle gaps:** alternate valid patterns with idle cycles. Expected: strict alternation under contention, state returns to IDLE when both valids are low, and ram_we, ram_addr and ram_din are 0 while idle.
